// File: rtl/nne_result_checker.sv
// Golden-model checker for the NAND/NOR/XOR gate stage: counts vectors, errors and covered {a,b} combinations.
// 1-cycle latency from accepted sample to counters/flags; never stalls, in_valid accepted every cycle in RUN.
module nne_result_checker #(
   parameter int ERR_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_clear,
   input  logic             i_in_valid,
   input  logic             i_in_a,
   input  logic             i_in_b,
   input  logic             i_in_t0,
   input  logic             i_in_t1,
   input  logic             i_in_t2,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic             o_err_flag,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic [CNT_W-1:0] o_vec_cnt,
   output logic [3:0]       o_seen_mask,
   output logic [1:0]       o_first_err_ab,
   output logic [2:0]       o_first_err_mask
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [ERR_W-1:0] ERR_MAX = '1;
   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
   localparam logic [CNT_W-1:0] VEC_MAX = '1;
   localparam logic [CNT_W-1:0] VEC_ONE = CNT_W'(1);

   state_t           r_state;
   logic             r_err_flag;
   logic [ERR_W-1:0] r_err_cnt;
   logic [CNT_W-1:0] r_vec_cnt;
   logic [3:0]       r_seen_mask;
   logic [1:0]       r_first_err_ab;
   logic [2:0]       r_first_err_mask;

   logic [1:0] w_idx;
   logic [2:0] w_exp;
   logic [2:0] w_mm;
   logic       w_err;
   logic       w_accept;
   logic [3:0] w_seen_nxt;

   // Golden model: bit order matches the stage outputs {nand, nor, xor}.
   assign w_idx      = {i_in_a, i_in_b};
   assign w_exp      = {~(i_in_a & i_in_b), ~(i_in_a | i_in_b), i_in_a ^ i_in_b};
   assign w_mm       = w_exp ^ {i_in_t0, i_in_t1, i_in_t2};
   assign w_err      = |w_mm;
   assign w_accept   = (r_state == RUN) && i_in_valid;
   assign w_seen_nxt = r_seen_mask | (4'b0001 << w_idx);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_state          <= IDLE;
         r_err_flag       <= 1'b0;
         r_err_cnt        <= '0;
         r_vec_cnt        <= '0;
         r_seen_mask      <= '0;
         r_first_err_ab   <= '0;
         r_first_err_mask <= '0;
      end else begin
         r_err_flag <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state          <= RUN;
                  r_err_cnt        <= '0;
                  r_vec_cnt        <= '0;
                  r_seen_mask      <= '0;
                  r_first_err_ab   <= '0;
                  r_first_err_mask <= '0;
               end
            end
            RUN: begin
               if (w_accept) begin
                  r_seen_mask <= w_seen_nxt;
                  if (r_vec_cnt != VEC_MAX) begin
                     r_vec_cnt <= r_vec_cnt + VEC_ONE;
                  end
                  if (w_err) begin
                     r_err_flag <= 1'b1;
                     if (r_err_cnt != ERR_MAX) begin
                        r_err_cnt <= r_err_cnt + ERR_ONE;
                     end
                     // First error of the run is latched only while the count is still zero.
                     if (r_err_cnt == '0) begin
                        r_first_err_ab   <= w_idx;
                        r_first_err_mask <= w_mm;
                     end
                  end
                  if (w_seen_nxt == 4'hF) begin
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               r_state <= DONE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_busy           = (r_state == RUN);
   assign o_done           = (r_state == DONE);
   assign o_pass           = (r_state == DONE) && (r_err_cnt == '0);
   assign o_err_flag       = r_err_flag;
   assign o_err_cnt        = r_err_cnt;
   assign o_vec_cnt        = r_vec_cnt;
   assign o_seen_mask      = r_seen_mask;
   assign o_first_err_ab   = r_first_err_ab;
   assign o_first_err_mask = r_first_err_mask;

endmodule
